stft_frame_buffer: RTL and testbench

- Windowing front end of the STFFT: accepts a continuous audio sample stream and emits overlapping frames of frame_len_p samples, advancing hop_p samples per frame.
- Samples are stored in a circular buffer built on the team's ram_1r1w_sync (synchronous write, 1-cycle registered read).
- Frames are streamed out over a valid/ready handshake with first/last markers to the FFT delay-buffer stage downstream.

---
 rtl/stft_pkg.sv | 21 ++
 rtl/stft_frame_buffer_if.sv | 38 +++
 rtl/ram_1r1w_sync.sv | 28 ++
 rtl/stft_frame_buffer.sv | 187 ++++++++++++++++++
 tb/tb_stft_frame_buffer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stft_pkg.sv
// Shared types and pointer-width helper for the STFT framing front end.
// No logic, so there is no latency and no backpressure to describe.
package stft_pkg;

  localparam int sample_width_c = 16;

  typedef logic [sample_width_c-1:0] sample_t;

  typedef enum logic {
    IDLE,
    STREAM
  } frame_state_e;

  // One extra bit beyond the address so a full buffer is distinguishable from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int ptr_width_c = ptr_width(2 * 8);

endpackage

// File: rtl/stft_frame_buffer_if.sv
// Sample-in / frame-out stream bundle for the STFT frame buffer.
// master is the stream environment, slave is the frame buffer.
interface stft_frame_buffer_if #(
  parameter int width_p = 16
) ();

  logic               in_valid_i;
  logic [width_p-1:0] in_data_i;
  logic               in_ready_o;
  logic               out_valid_o;
  logic [width_p-1:0] out_data_o;
  logic               out_first_o;
  logic               out_last_o;
  logic               out_ready_i;

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_first_o,
    input  out_last_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_first_o,
    output out_last_o
  );

endinterface

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: synchronous write, registered read data one cycle after r_v_i.
// No backpressure; read data holds until the next read.
module ram_1r1w_sync #(
  parameter  int width_p   = 16,
  parameter  int depth_p   = 16,
  localparam int addr_w_lp = $clog2(depth_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic                 r_v_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
    if (r_v_i) begin
      r_data_o <= mem[r_addr_i];
    end
  end

endmodule

// File: rtl/stft_frame_buffer.sv
// Circular sample buffer emitting overlapping frames of frame_len_p samples, hop_p apart.
// Read issue to out_valid_o is 2 cycles; in_ready_o drops when the buffer holds depth_p samples.
module stft_frame_buffer
  import stft_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int frame_len_p = 8,
  parameter int hop_p       = 4,
  parameter int depth_p     = 2 * frame_len_p
) (
  input logic                clk_i,
  input logic                reset_i,
  stft_frame_buffer_if.slave bus
);

  localparam int addr_w_lp = $clog2(depth_p);
  localparam int ptr_w_lp  = ptr_width(depth_p);
  localparam int idx_w_lp  = $clog2(frame_len_p);

  localparam logic [ptr_w_lp-1:0] depth_c     = ptr_w_lp'(depth_p);
  localparam logic [ptr_w_lp-1:0] frame_len_c = ptr_w_lp'(frame_len_p);
  localparam logic [ptr_w_lp-1:0] hop_c       = ptr_w_lp'(hop_p);
  localparam logic [idx_w_lp-1:0] last_idx_c  = idx_w_lp'(frame_len_p - 1);

  if (frame_len_p < 2 || (frame_len_p & (frame_len_p - 1)) != 0) begin : g_bad_frame_len
    $error("frame_len_p must be a power of two >= 2");
  end
  if (hop_p < 1 || hop_p > frame_len_p) begin : g_bad_hop
    $error("hop_p must lie in 1..frame_len_p");
  end
  if ((depth_p & (depth_p - 1)) != 0 || depth_p < frame_len_p + hop_p) begin : g_bad_depth
    $error("depth_p must be a power of two >= frame_len_p + hop_p");
  end

  logic [ptr_w_lp-1:0]  wr_cnt;
  logic [ptr_w_lp-1:0]  frame_start;
  logic [ptr_w_lp-1:0]  fill;
  logic [idx_w_lp-1:0]  rd_idx;
  logic [addr_w_lp-1:0] rd_addr;
  frame_state_e         state_q;
  frame_state_e         state_n;

  logic in_ready;
  logic wr_fire;
  logic rd_issue;
  logic rd_is_first;
  logic rd_is_last;
  logic credit_ok;
  logic [1:0] credit_used;

  logic [width_p-1:0] ram_rd_data;
  logic               rd_pend_q;
  logic               rd_first_q;
  logic               rd_last_q;

  logic [width_p-1:0] fifo_data [2];
  logic [1:0]         fifo_first;
  logic [1:0]         fifo_last;
  logic               fifo_wr_ptr;
  logic               fifo_rd_ptr;
  logic [1:0]         fifo_cnt;
  logic               fifo_push;
  logic               fifo_pop;
  logic               out_valid;

  assign fill     = wr_cnt - frame_start;
  assign in_ready = !reset_i && (fill < depth_c);
  assign wr_fire  = bus.in_valid_i && in_ready;

  assign rd_addr     = frame_start[addr_w_lp-1:0] + addr_w_lp'(rd_idx);
  assign rd_is_first = (rd_idx == '0);
  assign rd_is_last  = (rd_idx == last_idx_c);

  // A sample leaving the FIFO this cycle frees a slot, so it counts as a returned credit.
  assign out_valid   = (fifo_cnt != 2'd0);
  assign fifo_pop    = out_valid && bus.out_ready_i;
  assign fifo_push   = rd_pend_q;
  assign credit_used = fifo_cnt + {1'b0, rd_pend_q};
  assign credit_ok   = (credit_used < 2'd2) || fifo_pop;

  ram_1r1w_sync #(
    .width_p (width_p),
    .depth_p (depth_p)
  ) u_ram (
    .clk_i    (clk_i),
    .w_v_i    (wr_fire),
    .w_addr_i (wr_cnt[addr_w_lp-1:0]),
    .w_data_i (bus.in_data_i),
    .r_v_i    (rd_issue),
    .r_addr_i (rd_addr),
    .r_data_o (ram_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_cnt <= '0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + ptr_w_lp'(1);
    end
  end

  always_comb begin
    state_n  = state_q;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill >= frame_len_c) begin
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (credit_ok && !reset_i) begin
          rd_issue = 1'b1;
          if (rd_is_last) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      frame_start <= '0;
      rd_idx      <= '0;
    end else begin
      state_q <= state_n;
      if (rd_issue) begin
        if (rd_is_last) begin
          rd_idx      <= '0;
          frame_start <= frame_start + hop_c;
        end else begin
          rd_idx <= rd_idx + idx_w_lp'(1);
        end
      end
    end
  end

  // Markers travel beside the RAM read so they line up with its registered data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pend_q  <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_pend_q  <= rd_issue;
      rd_first_q <= rd_issue && rd_is_first;
      rd_last_q  <= rd_issue && rd_is_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_first   <= '0;
      fifo_last    <= '0;
      fifo_wr_ptr  <= 1'b0;
      fifo_rd_ptr  <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_data[fifo_wr_ptr]  <= ram_rd_data;
        fifo_first[fifo_wr_ptr] <= rd_first_q;
        fifo_last[fifo_wr_ptr]  <= rd_last_q;
        fifo_wr_ptr             <= !fifo_wr_ptr;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= !fifo_rd_ptr;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_valid ? fifo_data[fifo_rd_ptr] : '0;
  assign bus.out_first_o = out_valid && fifo_first[fifo_rd_ptr];
  assign bus.out_last_o  = out_valid && fifo_last[fifo_rd_ptr];

endmodule

// File: tb/tb_stft_frame_buffer.sv
// Directed bench for stft_frame_buffer: hop 4 and hop 8 instances, backpressure,
// random output stalls, pointer wraparound and reset in the middle of a frame.
module tb_stft_frame_buffer;
  import stft_pkg::*;

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stft_frame_buffer_if #(.width_p(16)) bus_a ();
  stft_frame_buffer_if #(.width_p(16)) bus_b ();

  stft_frame_buffer #(.width_p(16), .frame_len_p(8), .hop_p(4), .depth_p(16)) dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_a)
  );

  stft_frame_buffer #(.width_p(16), .frame_len_p(8), .hop_p(8), .depth_p(16)) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle expectations for the backpressure run: cycle index counted from the first
  // negedge after the reset preamble; reset is released at cycle 3.
  typedef struct {
    int          cyc;
    bit          in_rdy;
    bit          vld;
    bit          first;
    bit          last;
    logic [15:0] data;
  } vec_t;
  vec_t tbl [9];

  bit      ctl_feed = 1'b0;
  int      ctl_mode = 0;
  int      sent_a = 0;
  int      sent_b = 0;
  int      stab_bad = 0;
  int      stall_a = 0;
  bit      prev_stall = 1'b0;
  sample_t prev_d;
  bit      prev_f;
  bit      prev_l;

  sample_t q_data_a [$];
  bit      q_first_a [$];
  bit      q_last_a [$];
  sample_t q_data_b [$];
  bit      q_first_b [$];
  bit      q_last_b [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_frame(input string name, input bit use_b, input int pos, input int start);
    int miss = 0;
    int got0 = -1;
    for (int j = 0; j < 8; j++) begin
      int idx = pos + j;
      int sz = use_b ? q_data_b.size() : q_data_a.size();
      if (idx >= sz) begin
        miss++;
      end else begin
        sample_t d = use_b ? q_data_b[idx] : q_data_a[idx];
        bit      f = use_b ? q_first_b[idx] : q_first_a[idx];
        bit      l = use_b ? q_last_b[idx] : q_last_a[idx];
        if (j == 0) got0 = int'(d);
        if (d !== sample_t'(start + j) || f !== (j == 0) || l !== (j == 7)) miss++;
      end
    end
    total++;
    if (miss != 0) begin
      bad++;
      $display("FAIL %s at queue pos %0d: %0d of 8 samples wrong, first got 0x%0h expected 0x%0h",
               name, pos, miss, got0, sample_t'(start));
    end
  endtask

  // Stream driver/monitor for instance A: inputs change at negedge+1, transfers are
  // recorded at negedge+2 for the handshake completing on the following posedge.
  always begin
    @(negedge clk);
    #1;
    if (prev_stall && !rst) begin
      if (!bus_a.out_valid_o || bus_a.out_data_o !== prev_d ||
          bus_a.out_first_o !== prev_f || bus_a.out_last_o !== prev_l) stab_bad++;
    end
    bus_a.in_valid_i = ctl_feed;
    bus_a.in_data_i  = sample_t'(sent_a);
    case (ctl_mode)
      0:       bus_a.out_ready_i = 1'b0;
      1:       bus_a.out_ready_i = 1'b1;
      default: bus_a.out_ready_i = 1'($urandom & 1);
    endcase
    #1;
    if (!rst && bus_a.in_valid_i && bus_a.in_ready_o) sent_a++;
    if (!rst && bus_a.out_valid_o && bus_a.out_ready_i) begin
      q_data_a.push_back(bus_a.out_data_o);
      q_first_a.push_back(bus_a.out_first_o);
      q_last_a.push_back(bus_a.out_last_o);
    end
    prev_stall = !rst && bus_a.out_valid_o && !bus_a.out_ready_i;
    if (prev_stall) stall_a++;
    prev_d = bus_a.out_data_o;
    prev_f = bus_a.out_first_o;
    prev_l = bus_a.out_last_o;
  end

  // Instance B: 24 samples in, output always ready.
  always begin
    @(negedge clk);
    #1;
    bus_b.in_valid_i  = (sent_b < 24);
    bus_b.in_data_i   = sample_t'(sent_b);
    bus_b.out_ready_i = 1'b1;
    #1;
    if (!rst && bus_b.in_valid_i && bus_b.in_ready_o) sent_b++;
    if (!rst && bus_b.out_valid_o && bus_b.out_ready_i) begin
      q_data_b.push_back(bus_b.out_data_o);
      q_first_b.push_back(bus_b.out_first_o);
      q_last_b.push_back(bus_b.out_last_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti = 0;
    int nfr;
    int pos0;
    int pos2;
    int base;
    int base2;
    bit saw_rdy;

    tbl[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3] = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{13, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{14, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[6] = '{18, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[7] = '{19, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[8] = '{24, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};

    ctl_feed = 1'b1;
    ctl_mode = 0;
    repeat (2) @(negedge clk);

    // Output held off, input always offered: fills to 16 then stalls.
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      rst = (c < 3);
      #3;
      if (c == 0) check("reset in_ready b", int'(bus_b.in_ready_o), 0);
      if (ti < 9 && tbl[ti].cyc == c) begin
        check($sformatf("c%0d in_ready", c), int'(bus_a.in_ready_o), int'(tbl[ti].in_rdy));
        check($sformatf("c%0d out_valid", c), int'(bus_a.out_valid_o), int'(tbl[ti].vld));
        check($sformatf("c%0d out_first", c), int'(bus_a.out_first_o), int'(tbl[ti].first));
        check($sformatf("c%0d out_last", c), int'(bus_a.out_last_o), int'(tbl[ti].last));
        check($sformatf("c%0d out_data", c), int'(bus_a.out_data_o), int'(tbl[ti].data));
        ti++;
      end
    end
    check("bp accepted count", sent_a, 16);

    // Release the output: frame 0 drains and the input side opens again.
    ctl_mode = 1;
    saw_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus_a.in_ready_o) saw_rdy = 1'b1;
      if (q_data_a.size() >= 8) break;
    end
    check("release frame0 drained", int'(q_data_a.size() >= 8), 1);
    check("release in_ready back", int'(saw_rdy), 1);

    ctl_mode = 2;
    repeat (200) @(negedge clk);

    ctl_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sent_a >= 1000) break;
    end
    check("long run reached 1000", int'(sent_a >= 1000), 1);
    ctl_feed = 1'b0;
    repeat (60) @(negedge clk);
    #3;

    nfr = (sent_a - 8) / 4 + 1;
    check("frame count a", q_data_a.size(), nfr * 8);
    for (int k = 0; k < q_data_a.size() / 8; k++) begin
      check_frame($sformatf("a frame %0d", k), 1'b0, 8 * k, 4 * k);
    end
    check("hold stable in stalls", stab_bad, 0);
    check("stalls exercised", int'(stall_a > 0), 1);

    check("frame count b", q_data_b.size(), 24);
    for (int k = 0; k < 3; k++) begin
      check_frame($sformatf("b frame %0d", k), 1'b1, 8 * k, 8 * k);
    end

    // Fresh start, then reset while the 3rd sample of frame 1 is on the output.
    pos0 = q_data_a.size();
    ctl_feed = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = sent_a;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (q_data_a.size() >= pos0 + 10) break;
    end
    check("pre-reset progress", int'(q_data_a.size() >= pos0 + 10), 1);
    check_frame("restart frame 0", 1'b0, pos0, base);

    @(negedge clk);
    rst = 1'b1;
    #3;
    check("3rd sample valid", int'(bus_a.out_valid_o), 1);
    check("3rd sample data", int'(bus_a.out_data_o), int'(sample_t'(base + 6)));
    check("3rd sample first", int'(bus_a.out_first_o), 0);
    @(negedge clk);
    #3;
    check("in reset out_valid", int'(bus_a.out_valid_o), 0);
    check("in reset in_ready", int'(bus_a.in_ready_o), 0);
    check("in reset out_data", int'(bus_a.out_data_o), 0);
    @(negedge clk);
    base2 = sent_a;
    pos2 = q_data_a.size();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (q_data_a.size() >= pos2 + 8) break;
    end
    check_frame("post-reset frame", 1'b0, pos2, base2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
